// File: rtl/obstacle_pkg.sv
// obstacle_pkg
// Shared definitions for the obstacle scroller: pass FSM state encoding,
// default geometry/parameter values, and the LFSR seed and feedback taps.
package obstacle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    CHECK,
    DRAW,
    DONE
  } state_e;

  localparam int DEF_SCREEN_W    = 160;
  localparam int DEF_X_W         = 8;
  localparam int DEF_Y_W         = 7;
  localparam int DEF_NUM_OBS     = 2;
  localparam int DEF_OBS_W       = 4;
  localparam int DEF_GROUND_Y    = 115;
  localparam int DEF_MIN_H       = 8;
  localparam int DEF_HB          = 3;
  localparam int DEF_START_X     = 100;
  localparam int DEF_SPACING     = 80;
  localparam int DEF_PLAYER_SIZE = 4;
  localparam logic [2:0] DEF_OBS_COLOUR = 3'b111;

  localparam int          LFSR_W    = 13;
  localparam logic [12:0] LFSR_SEED = 13'd7;
  // feedback = bit12 ^ bit3 ^ bit2 ^ bit0
  localparam logic [12:0] LFSR_TAPS = 13'b1_0000_0000_1101;

endpackage

// File: rtl/obstacle_lfsr.sv
// obstacle_lfsr
// 13-bit Fibonacci LFSR, free-running (shifts every cycle), seeded on reset.
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset
//   lfsr_o - full LFSR register
module obstacle_lfsr
  import obstacle_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic              fb;

  assign fb     = ^(lfsr_q & LFSR_TAPS);
  assign lfsr_o = lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[LFSR_W-2:0], fb};
  end

endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller
// Multi-obstacle engine: one pass per start = move/respawn, collision check,
// then stream obstacle pixels one per cycle, then a one-cycle done pulse.
// Ports:
//   clk_i, rst_i            - clock, async active-high reset
//   start_i, step_i, speed_i - pass request, advance enable, pixels per step
//   clear_i                 - synchronous game restart
//   player_x_i, player_y_i  - player box top-left corner
//   x_o, y_o, colour_o, plot_o - registered pixel write port
//   busy_o, done_o          - pass in progress / end-of-pass pulse
//   hit_o, score_o          - sticky collision flag / saturating score
module obstacle_scroller
  import obstacle_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int NUM_OBS     = DEF_NUM_OBS,
  parameter int OBS_W       = DEF_OBS_W,
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int MIN_H       = DEF_MIN_H,
  parameter int HB          = DEF_HB,
  parameter int START_X     = DEF_START_X,
  parameter int SPACING     = DEF_SPACING,
  parameter int PLAYER_SIZE = DEF_PLAYER_SIZE,
  parameter logic [2:0] OBS_COLOUR = DEF_OBS_COLOUR
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           step_i,
  input  logic [2:0]     speed_i,
  input  logic           clear_i,
  input  logic [X_W-1:0] player_x_i,
  input  logic [Y_W-1:0] player_y_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic [2:0]     colour_o,
  output logic           plot_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           hit_o,
  output logic [7:0]     score_o
);

  localparam int PW = X_W + 1;
  localparam int IW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int CW = $clog2(OBS_W) + 1;

  function automatic logic [PW-1:0] init_x(input int i);
    return PW'(START_X + i * SPACING);
  endfunction

  state_e state_q, state_d;
  logic [PW-1:0]  ox_q [NUM_OBS];
  logic [PW-1:0]  ox_d [NUM_OBS];
  logic [Y_W-1:0] h_q  [NUM_OBS];
  logic [Y_W-1:0] h_d  [NUM_OBS];
  logic [7:0]     score_q, score_d;
  logic           hit_q, hit_d;
  logic           step_q, step_d;
  logic [2:0]     speed_q, speed_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [Y_W-1:0] row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [2:0]     colour_q, colour_d;
  logic           plot_q, plot_d;

  logic [LFSR_W-1:0] lfsr;
  logic [NUM_OBS-1:0] on_scr;
  logic [IW-1:0]  first_idx, adv_idx, pix_idx;
  logic [Y_W-1:0] adv_row, pix_row;
  logic [CW-1:0]  adv_col, pix_col;
  logic           adv_end, hit_now;
  logic [PW-1:0]  pix_x, spawn_x;
  logic [Y_W-1:0] pix_y, spawn_h;
  logic [8:0]     score_sum;
  int             nresp;

  obstacle_lfsr u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .lfsr_o (lfsr)
  );

  assign spawn_x = PW'(SCREEN_W) + PW'({lfsr[HB+1:HB], 3'b000});
  assign spawn_h = Y_W'(MIN_H) + Y_W'(lfsr[HB-1:0]);

  // Visibility, first drawable obstacle, walker successor and collision.
  always_comb begin
    first_idx = '0;
    adv_idx   = idx_q;
    adv_row   = row_q;
    adv_col   = col_q;
    adv_end   = 1'b0;
    hit_now   = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) on_scr[i] = (ox_q[i] < PW'(SCREEN_W));
    for (int i = NUM_OBS - 1; i >= 0; i--) if (on_scr[i]) first_idx = IW'(i);
    if (col_q != CW'(OBS_W - 1)) begin
      adv_col = col_q + CW'(1);
    end else begin
      adv_col = '0;
      if (row_q != h_q[idx_q] - Y_W'(1)) begin
        adv_row = row_q + Y_W'(1);
      end else begin
        adv_row = '0;
        adv_end = 1'b1;
        // descending scan leaves the lowest visible index above idx_q
        for (int j = NUM_OBS - 1; j >= 0; j--) begin
          if (j > int'(idx_q) && on_scr[j]) begin
            adv_idx = IW'(j);
            adv_end = 1'b0;
          end
        end
      end
    end
    for (int i = 0; i < NUM_OBS; i++) begin
      if (on_scr[i] &&
          int'(player_x_i) <= int'(ox_q[i]) + OBS_W - 1 &&
          int'(ox_q[i]) <= int'(player_x_i) + PLAYER_SIZE - 1 &&
          int'(player_y_i) <= GROUND_Y - 1 &&
          GROUND_Y - int'(h_q[i]) <= int'(player_y_i) + PLAYER_SIZE - 1)
        hit_now = 1'b1;
    end
  end

  // CHECK emits the first pixel of the pass; DRAW emits the successor.
  assign pix_idx = (state_q == CHECK) ? first_idx : adv_idx;
  assign pix_row = (state_q == CHECK) ? '0 : adv_row;
  assign pix_col = (state_q == CHECK) ? '0 : adv_col;
  assign pix_x   = ox_q[pix_idx] + PW'(pix_col);
  assign pix_y   = Y_W'(GROUND_Y) - h_q[pix_idx] + pix_row;

  always_comb begin
    state_d  = state_q;
    ox_d     = ox_q;
    h_d      = h_q;
    score_d  = score_q;
    hit_d    = hit_q;
    step_d   = step_q;
    speed_d  = speed_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    plot_d   = 1'b0;
    nresp    = 0;
    score_sum = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = MOVE;
          step_d  = step_i;
          speed_d = speed_i;
        end
      end
      MOVE: begin
        if (step_q) begin
          for (int i = 0; i < NUM_OBS; i++) begin
            if (ox_q[i] < PW'(speed_q)) begin
              ox_d[i] = spawn_x;
              h_d[i]  = spawn_h;
              nresp   = nresp + 1;
            end else begin
              ox_d[i] = ox_q[i] - PW'(speed_q);
            end
          end
          score_sum = {1'b0, score_q} + 9'(nresp);
          score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
        end
        state_d = CHECK;
      end
      CHECK, DRAW: begin
        if (state_q == CHECK && hit_now) hit_d = 1'b1;
        if ((state_q == CHECK && on_scr == '0) || (state_q == DRAW && adv_end)) begin
          state_d = DONE;
        end else begin
          state_d  = DRAW;
          idx_d    = pix_idx;
          row_d    = pix_row;
          col_d    = pix_col;
          x_d      = pix_x[X_W-1:0];
          y_d      = pix_y;
          plot_d   = (pix_x < PW'(SCREEN_W));
          colour_d = plot_d ? OBS_COLOUR : 3'b000;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d  = IDLE;
      score_d  = '0;
      hit_d    = 1'b0;
      x_d      = '0;
      y_d      = '0;
      colour_d = '0;
      plot_d   = 1'b0;
      for (int i = 0; i < NUM_OBS; i++) begin
        ox_d[i] = init_x(i);
        h_d[i]  = Y_W'(MIN_H);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      score_q  <= '0;
      hit_q    <= 1'b0;
      step_q   <= 1'b0;
      speed_q  <= '0;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      for (int i = 0; i < NUM_OBS; i++) begin
        ox_q[i] <= init_x(i);
        h_q[i]  <= Y_W'(MIN_H);
      end
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      step_q   <= step_d;
      speed_q  <= speed_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      for (int i = 0; i < NUM_OBS; i++) begin
        ox_q[i] <= ox_d[i];
        h_q[i]  <= h_d[i];
      end
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign colour_o = colour_q;
  assign plot_o   = plot_q;
  assign busy_o   = (state_q != IDLE) && (state_q != DONE);
  assign done_o   = (state_q == DONE);
  assign hit_o    = hit_q;
  assign score_o  = score_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// tb_obstacle_scroller
// Directed bench for obstacle_scroller with hand-computed expectations.
module tb_obstacle_scroller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, step = 1'b0, clear = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [7:0] player_x = 8'd0;
  logic [6:0] player_y = 7'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done, hit;
  logic [7:0] score;

  int checks = 0;
  int failures = 0;

  logic [7:0] px [256];
  logic [6:0] py [256];
  logic       pp [256];
  logic [2:0] pc [256];
  int npix, done_cyc, busy_bad;
  logic hit_c2, hit_c3;

  obstacle_scroller dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .step_i(step), .speed_i(speed),
    .clear_i(clear), .player_x_i(player_x), .player_y_i(player_y),
    .x_o(x), .y_o(y), .colour_o(colour), .plot_o(plot),
    .busy_o(busy), .done_o(done), .hit_o(hit), .score_o(score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " x"}, 32'(x), 0);
    check({tag, " y"}, 32'(y), 0);
    check({tag, " colour"}, 32'(colour), 0);
    check({tag, " plot"}, 32'(plot), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
  endtask

  // One full pass: start at edge 0, record pixel cycles until done.
  task automatic do_pass(input string tag, input logic stp, input logic [2:0] spd, input int exp_p);
    int cyc;
    bit seen;
    step = stp; speed = spd; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    npix = 0; seen = 0; cyc = 1; done_cyc = -1; busy_bad = 0;
    while (!seen && cyc < 2000) begin
      if (cyc == 2) hit_c2 = hit;
      if (cyc == 3) hit_c3 = hit;
      if (done) begin
        seen = 1; done_cyc = cyc;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        if (cyc >= 3 && npix < 256) begin
          px[npix] = x; py[npix] = y; pp[npix] = plot; pc[npix] = colour;
          npix++;
        end
        @(posedge clk); #1; cyc++;
      end
    end
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(3 + exp_p));
    check({tag, " busy_during"}, 32'(busy_bad), 0);
    @(posedge clk); #1;
    check({tag, " busy_after"}, 32'(busy), 0);
    check({tag, " done_after"}, 32'(done), 0);
  endtask

  // Expected stream of one h x 4 obstacle starting at recorded index base.
  task automatic check_obs(input string tag, input int base, input int ox, input int h);
    int bad, ex, ey;
    logic ep;
    bad = 0;
    for (int k = 0; k < h * 4; k++) begin
      ex = ox + k % 4;
      ey = 115 - h + k / 4;
      ep = (ex < 160);
      if (px[base+k] !== 8'(ex) || py[base+k] !== 7'(ey) || pp[base+k] !== ep ||
          pc[base+k] !== (ep ? 3'd7 : 3'd0)) bad++;
    end
    check(tag, 32'(bad), 0);
  endtask

  initial begin
    int plotted, exp_p;

    // reset state
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check_idle_outputs("reset");
    check("reset hit", 32'(hit), 0);
    check("reset score", 32'(score), 0);
    repeat (3) @(posedge clk);
    #1; check_idle_outputs("pre_start");

    // first pass, no stepping: only obstacle 0 at 100 is visible
    do_pass("passA", 1'b0, 3'd4, 32);
    check_obs("passA pixels", 0, 100, 8);
    check("passA hit", 32'(hit), 0);
    check("passA score", 32'(score), 0);

    // stepping with speed 0 leaves positions unchanged
    do_pass("speed0", 1'b1, 3'd0, 32);
    check_obs("speed0 pixels", 0, 100, 8);

    // collision: just left of the obstacle, then overlapping, then sticky
    player_x = 8'd95; player_y = 7'd111;
    do_pass("miss", 1'b0, 3'd0, 32);
    check("miss hit", 32'(hit_c3), 0);
    player_x = 8'd100;
    do_pass("overlap", 1'b0, 3'd0, 32);
    check("overlap hit before check", 32'(hit_c2), 0);
    check("overlap hit after check", 32'(hit_c3), 1);
    player_x = 8'd0; player_y = 7'd0;
    do_pass("sticky", 1'b0, 3'd0, 32);
    check("sticky hit", 32'(hit), 1);

    // speed 4: obstacle 0 reaches 0 after 25 passes, respawns on the 26th
    for (int k = 1; k <= 25; k++) begin
      exp_p = 32 + ((180 - 4 * k) < 160 ? 32 : 0);
      do_pass($sformatf("spd pass%0d", k), 1'b1, 3'd4, exp_p);
    end
    check_obs("spd25 obs0", 0, 0, 8);
    check_obs("spd25 obs1", 32, 80, 8);
    check("spd25 score", 32'(score), 0);
    do_pass("spd pass26", 1'b1, 3'd4, 32);
    check_obs("spd26 obs1", 0, 76, 8);
    check("spd26 score", 32'(score), 1);
    check("spd26 hit", 32'(hit), 1);

    // clear in the middle of drawing
    step = 1'b1; speed = 3'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_clear busy", 32'(busy), 1);
    clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    check_idle_outputs("clear");
    check("clear score", 32'(score), 0);
    check("clear hit", 32'(hit), 0);
    @(posedge clk); #1;
    check("clear no_done", 32'(done), 0);
    do_pass("post_clear", 1'b0, 3'd0, 32);
    check_obs("post_clear pixels", 0, 100, 8);

    // right-edge clipping: speed 2 brings obstacle 1 to 158 after 11 passes
    for (int k = 1; k <= 10; k++) do_pass($sformatf("clip pass%0d", k), 1'b1, 3'd2, 32);
    do_pass("clip pass11", 1'b1, 3'd2, 64);
    check_obs("clip obs0", 0, 78, 8);
    check_obs("clip obs1", 32, 158, 8);
    plotted = 0;
    for (int k = 0; k < 64; k++) if (pp[k] === 1'b1) plotted++;
    check("clip plotted count", 32'(plotted), 48);

    // asynchronous reset mid-draw
    step = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset plot", 32'(plot), 1);
    #2; rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset hit", 32'(hit), 0);
    check("async_reset score", 32'(score), 0);
    @(posedge clk); #1; rst = 1'b0;
    do_pass("after_reset", 1'b0, 3'd0, 32);
    check_obs("after_reset pixels", 0, 100, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
